// File: rtl/lb_dispatch_scheduler.sv
// Load-balancing dispatcher: routes one HTTP request (meta + optional body) to the least-loaded region.
// Optional LB_OID_AFFINITY_EN: prefer the tied region that last served the same OID.
module lb_dispatch_scheduler #(
  parameter int HTTP_DATA_WIDTH   = 512,
  parameter int HTTP_META_WIDTH   = 98,
  parameter int OPERATOR_ID_WIDTH = 16,
  parameter int N_REGIONS         = 4,
  parameter int MAX_OUTSTANDING   = 15,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1),
  localparam int SW = $clog2(N_REGIONS)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         meta_in_tvalid,
  output logic                         meta_in_tready,
  input  logic [HTTP_META_WIDTH-1:0]   meta_in_tdata,
  input  logic                         bdy_in_tvalid,
  output logic                         bdy_in_tready,
  input  logic [HTTP_DATA_WIDTH-1:0]   bdy_in_tdata,
  input  logic                         bdy_in_tlast,
  output logic [N_REGIONS-1:0]         meta_out_tvalid,
  input  logic [N_REGIONS-1:0]         meta_out_tready,
  output logic [HTTP_META_WIDTH-1:0]   meta_out_tdata,
  output logic [N_REGIONS-1:0]         bdy_out_tvalid,
  input  logic [N_REGIONS-1:0]         bdy_out_tready,
  output logic [HTTP_DATA_WIDTH-1:0]   bdy_out_tdata,
  output logic                         bdy_out_tlast,
  input  logic [N_REGIONS-1:0]         done_in,
  output logic [N_REGIONS*CW-1:0]      region_load,
  output logic [SW-1:0]                lb_sel,
  output logic                         cnt_err
);

  typedef enum logic [1:0] {
    IDLE,
    DECIDE,
    SEND_META,
    SEND_BDY
  } state_e;

  // has_body sits directly above the OID field
  localparam int HB = OPERATOR_ID_WIDTH;
  localparam logic [CW-1:0] MAXV = CW'(MAX_OUTSTANDING);

  state_e                       state_q;
  logic [HTTP_META_WIDTH-1:0]   meta_q;
  logic [SW-1:0]                sel_q;
  logic [SW-1:0]                rr_q;
  logic [CW-1:0]                load_q [N_REGIONS];
  logic                         err_q;
  logic                         rdy_q;
  logic [N_REGIONS-1:0]         mvld_q;

`ifdef LB_OID_AFFINITY_EN
  logic [OPERATOR_ID_WIDTH-1:0] oid_q [N_REGIONS];
`endif

  logic                 any_elig;
  logic                 found;
  logic [CW-1:0]        min_ld;
  logic [SW-1:0]        pick;
  logic [SW-1:0]        idx;
  logic [N_REGIONS-1:0] pick_hot;
  logic [N_REGIONS-1:0] sel_hot;
  logic [N_REGIONS-1:0] disp_vec;
  logic                 meta_hs;
  logic                 in_bdy;

  always_comb begin
    any_elig = 1'b0;
    found    = 1'b0;
    min_ld   = '1;
    pick     = rr_q;
    idx      = rr_q;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (load_q[i] < MAXV && (!any_elig || load_q[i] < min_ld)) begin
        any_elig = 1'b1;
        min_ld   = load_q[i];
      end
    end
    // Scan from rr so the first tied region at or after rr wins
    for (int k = 0; k < N_REGIONS; k++) begin
      idx = SW'(rr_q + SW'(k));
      if (!found && load_q[idx] == min_ld && load_q[idx] < MAXV) begin
        found = 1'b1;
        pick  = idx;
      end
    end
`ifdef LB_OID_AFFINITY_EN
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (any_elig && load_q[i] == min_ld &&
          oid_q[i] == meta_q[OPERATOR_ID_WIDTH-1:0]) begin
        pick = SW'(i);
      end
    end
`endif
  end

  assign pick_hot = N_REGIONS'(1) << pick;
  assign sel_hot  = N_REGIONS'(1) << sel_q;
  assign disp_vec = mvld_q & meta_out_tready;
  assign meta_hs  = |disp_vec;
  assign in_bdy   = (state_q == SEND_BDY);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      meta_q  <= '0;
      sel_q   <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      mvld_q  <= '0;
      for (int i = 0; i < N_REGIONS; i++) begin
        load_q[i] <= '0;
`ifdef LB_OID_AFFINITY_EN
        oid_q[i]  <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < N_REGIONS; i++) begin
        if (disp_vec[i] && !done_in[i]) begin
          load_q[i] <= load_q[i] + CW'(1);
        end else if (!disp_vec[i] && done_in[i]) begin
          if (load_q[i] == '0) err_q <= 1'b1;
          else load_q[i] <= load_q[i] - CW'(1);
        end
      end
      unique case (state_q)
        IDLE: begin
          if (meta_in_tvalid && rdy_q) begin
            meta_q  <= meta_in_tdata;
            rdy_q   <= 1'b0;
            state_q <= DECIDE;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        DECIDE: begin
          if (any_elig) begin
            sel_q   <= pick;
            mvld_q  <= pick_hot;
            state_q <= SEND_META;
          end
        end
        SEND_META: begin
          if (meta_hs) begin
            mvld_q <= '0;
            rr_q   <= sel_q + SW'(1);
`ifdef LB_OID_AFFINITY_EN
            oid_q[sel_q] <= meta_q[OPERATOR_ID_WIDTH-1:0];
`endif
            if (meta_q[HB]) begin
              state_q <= SEND_BDY;
            end else begin
              state_q <= IDLE;
              rdy_q   <= 1'b1;
            end
          end
        end
        SEND_BDY: begin
          if (bdy_in_tvalid && bdy_in_tready && bdy_in_tlast) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign meta_in_tready  = rdy_q;
  assign meta_out_tvalid = mvld_q;
  assign meta_out_tdata  = meta_q;
  assign bdy_out_tvalid  = (in_bdy && bdy_in_tvalid) ? sel_hot : '0;
  assign bdy_in_tready   = in_bdy & bdy_out_tready[sel_q];
  assign bdy_out_tdata   = in_bdy ? bdy_in_tdata : '0;
  assign bdy_out_tlast   = in_bdy & bdy_in_tlast;
  assign lb_sel          = sel_q;
  assign cnt_err         = err_q;

  for (genvar r = 0; r < N_REGIONS; r++) begin : g_load
    assign region_load[r*CW +: CW] = load_q[r];
  end

endmodule

// File: doc/lb_dispatch_scheduler.md
Name: lb_dispatch_scheduler

Overview:
Sequences HTTP requests from the HTTP module to N_REGIONS region proxies. Accepts one request at a time: meta beat, then optional body burst. Picks the target region from its own per-region outstanding-request counters, then streams the request to that region only. Sits between the HTTP module output and the region proxy inputs. Maintains its own load view from dispatch and completion events.

Parameters:
HTTP_DATA_WIDTH, 512, body beat width
HTTP_META_WIDTH, 98, meta word width; OID in [15:0], has_body in [16]
OPERATOR_ID_WIDTH, 16, operator id width
N_REGIONS, 4, number of regions; power of two, >=2
MAX_OUTSTANDING, 15, per-region in-flight cap; counter width CW = $clog2(MAX_OUTSTANDING+1)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
meta_in_tvalid  in  1  request meta valid
meta_in_tready  out  1  meta accepted when both high
meta_in_tdata  in  HTTP_META_WIDTH  request meta
bdy_in_tvalid  in  1  body beat valid
bdy_in_tready  out  1  body beat ready
bdy_in_tdata  in  HTTP_DATA_WIDTH  body beat
bdy_in_tlast  in  1  last body beat
meta_out_tvalid  out  N_REGIONS  one-hot meta valid to the selected region
meta_out_tready  in  N_REGIONS  per-region meta ready
meta_out_tdata  out  HTTP_META_WIDTH  registered meta, shared by all regions
bdy_out_tvalid  out  N_REGIONS  one-hot body valid
bdy_out_tready  in  N_REGIONS  per-region body ready
bdy_out_tdata  out  HTTP_DATA_WIDTH  body data, shared
bdy_out_tlast  out  1  body last, shared
done_in  in  N_REGIONS  1-cycle pulse per region on request completion
region_load  out  N_REGIONS*CW  current outstanding counters
lb_sel  out  $clog2(N_REGIONS)  last selected region
cnt_err  out  1  sticky: done_in seen on a zero counter

Behaviour:
- Reset (async assert, sync release): state IDLE, all tvalid/tready = 0, counters = 0, lb_sel = 0, cnt_err = 0, rr pointer = 0, tdata outputs = 0.
- FSM states: IDLE, DECIDE, SEND_META, SEND_BDY.
- IDLE: meta_in_tready = 1. On handshake, register the meta word and go to DECIDE.
- DECIDE: eligible = regions with load < MAX_OUTSTANDING. Choose the minimum load among eligible regions. Break ties with the round-robin pointer: first tied index >= rr, wrapping. Register lb_sel, go to SEND_META.
  - If no region is eligible, stay in DECIDE. Re-evaluate each cycle.
- SEND_META: meta_out_tvalid[lb_sel] = 1, other bits 0. Data is held stable until meta_out_tready[lb_sel].
  - On handshake: increment load[lb_sel] and set rr = lb_sel+1 (mod N).
  - Next state: SEND_BDY if has_body = 1, else IDLE.
- SEND_BDY: pass-through with no registering.
  - bdy_out_tvalid[lb_sel] = bdy_in_tvalid.
  - bdy_in_tready = bdy_out_tready[lb_sel].
  - Data and last are forwarded.
  - A handshake with tlast returns to IDLE.
- Latency: meta accepted in cycle N → meta_out_tvalid is first asserted in cycle N+2.
- meta_in_tready and bdy_in_tready are never both 1. bdy_in_tready = 0 outside SEND_BDY.
- Counters:
  - Dispatch and done_in on the same region in the same cycle → net unchanged.
  - done_in on a zero counter → counter stays 0, cnt_err set (sticky until reset).
  - Increment never exceeds MAX_OUTSTANDING, guaranteed by the eligibility check.
  - Multiple done_in bits in one cycle are each applied.
- Counters update in every state, including while stalled.
- Reset mid-request: outputs drop immediately and the transfer is abandoned. Upstream must also be reset.

Optional Feature:
LB_OID_AFFINITY_EN
- Defined: keep a per-region last-dispatched OID register (reset 0). In DECIDE, among min-load tied regions, prefer the lowest index whose last OID equals the request OID. Fall back to round-robin if none matches. Update the register on meta dispatch.
- Undefined: pure round-robin tie-break; the OID registers are absent.

Test Plan:
1. Reset, loads all 0, four requests with has_body=0 and no done → regions 0,1,2,3 in order; region_load = 1 each; each meta_out_tvalid first high 2 cycles after acceptance.
2. Preload loads {3,1,2,1}, rr=0, new request → region 1. Next request while region 1 is at 2 → region 3.
3. Request with has_body=1, 4 body beats, bdy_out_tready[sel] toggling 1/0 → exactly 4 beats delivered in order to sel only; tlast on beat 4; state returns to IDLE.
4. MAX_OUTSTANDING=2, all regions at 2, request arrives → stalls in DECIDE, meta_in_tready = 0. Pulse done_in[2] → dispatched to region 2 within 2 cycles.
5. done_in[0] on load 0 → cnt_err = 1 and load stays 0. Same-cycle dispatch+done to region 1 at load 1 → load stays 1.
6. LB_OID_AFFINITY_EN: loads equal, region 2 last served OID 0x0007, request OID 0x0007, rr=0 → region 2. Without the macro → region 0.
